bias_add_ctrl: RTL and testbench

Sequencer for the expand-layer bias-add stage. It walks output-channel groups of 8 channels: one 64-bit bias word per group (4× 3x3 + 4× 1x1, 8-bit each). For each group it fetches the bias word from the bias buffer and holds it stable on the datapath's bias input. It then admits that group's pixels, drives the add/ReLU enables and tracks results through the fixed-latency adder pipeline. It sits between the expand-layer convolution output and the max-pool stage, beside the 8-lane 12-bit bias-add datapath.

---
 rtl/bias_add_ctrl_pkg.sv | 17 +
 rtl/bias_add_ctrl_valid_delay_line.sv | 32 +++
 rtl/bias_add_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bias_add_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_ctrl_pkg.sv
// Shared types and constants for the expand-layer bias-add sequencer.
package bias_add_ctrl_pkg;

  localparam int BIAS_W      = 64;
  localparam int LANE_W      = 8;
  // Pipeline depth of the 12-bit bias adder in the datapath.
  localparam int ADD_LAT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/bias_add_ctrl_valid_delay_line.sv
// Fixed-depth shift register with synchronous clear; one register per stage.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] data_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) data_reg <= '0;
          else     data_reg <= d;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) data_reg <= '0;
          else     data_reg <= g_stage[gi-1].data_reg;
        end
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/bias_add_ctrl.sv
// Bias-add sequencer: fetches one bias word per 8-channel group, admits the
// group's pixels and tracks results through the fixed-latency adder.
module bias_add_ctrl
  import bias_add_ctrl_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int RD_LAT  = 1,
  parameter int GRP_W   = 8,
  parameter int PIX_W   = 16,
  parameter int ADDR_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [GRP_W-1:0]  cfg_grp_num_i,
  input  logic [PIX_W-1:0]  cfg_pix_num_i,
  input  logic [ADDR_W-1:0] cfg_bias_base_i,
  input  logic              cfg_relu_en_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bias_rd_en_o,
  output logic [ADDR_W-1:0] bias_rd_addr_o,
  input  logic [BIAS_W-1:0] bias_rd_data_i,
  output logic [BIAS_W-1:0] bias_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              add_en_o,
  output logic              skip_neg_en_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic [GRP_W-1:0]  grp_idx_o
);

  localparam int WAIT_W = $clog2(RD_LAT + 2);
  localparam int INF_W  = $clog2(ADD_LAT + 2);

  state_t              state_reg, state_next;
  logic [GRP_W-1:0]    grp_cnt_reg, grp_cnt_next;
  logic [PIX_W-1:0]    pix_cnt_reg, pix_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [INF_W-1:0]    inflight_reg, inflight_next;
  logic [GRP_W-1:0]    cfg_grp_reg;
  logic [PIX_W-1:0]    cfg_pix_reg;
  logic [ADDR_W-1:0]   cfg_base_reg;
  logic                relu_reg;
  logic [BIAS_W-1:0]   bias_reg;

  logic                add_en;
  logic                pix_last;
  logic                grp_last;
  logic                drained;
  logic [GRP_W+1:0]    track_in, track_out;

  assign add_en   = in_valid_i && (state_reg == RUN);
  assign pix_last = (pix_cnt_reg == cfg_pix_reg - PIX_W'(1));
  assign grp_last = !(grp_cnt_reg < cfg_grp_reg - GRP_W'(1));
  // The beat leaving the tail this cycle counts as gone, so done_o lands
  // exactly one cycle after the final out_valid_o.
  assign drained  = (inflight_reg == '0) ||
                    ((inflight_reg == INF_W'(1)) && out_valid_o);

  always_comb begin
    state_next    = state_reg;
    grp_cnt_next  = grp_cnt_reg;
    pix_cnt_next  = pix_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          grp_cnt_next  = '0;
          pix_cnt_next  = '0;
          wait_cnt_next = '0;
          if (cfg_grp_num_i == '0 || cfg_pix_num_i == '0) state_next = DONE;
          else                                            state_next = LOAD;
        end
      end
      LOAD: begin
        if (wait_cnt_reg == WAIT_W'(RD_LAT + 1)) state_next = RUN;
        else                                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
      RUN: begin
        if (add_en) begin
          if (pix_last) begin
            pix_cnt_next = '0;
            if (!grp_last) begin
              grp_cnt_next  = grp_cnt_reg + GRP_W'(1);
              wait_cnt_next = '0;
              state_next    = LOAD;
            end else begin
              state_next = DRAIN;
            end
          end else begin
            pix_cnt_next = pix_cnt_reg + PIX_W'(1);
          end
        end
      end
      DRAIN: if (drained) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    inflight_next = inflight_reg;
    case ({add_en, out_valid_o})
      2'b10:   inflight_next = inflight_reg + INF_W'(1);
      2'b01:   inflight_next = inflight_reg - INF_W'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      grp_cnt_reg  <= '0;
      pix_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      inflight_reg <= '0;
      cfg_grp_reg  <= '0;
      cfg_pix_reg  <= '0;
      cfg_base_reg <= '0;
      relu_reg     <= 1'b0;
      bias_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      grp_cnt_reg  <= grp_cnt_next;
      pix_cnt_reg  <= pix_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      inflight_reg <= inflight_next;
      if (state_reg == IDLE && start_i) begin
        cfg_grp_reg  <= cfg_grp_num_i;
        cfg_pix_reg  <= cfg_pix_num_i;
        cfg_base_reg <= cfg_bias_base_i;
        relu_reg     <= cfg_relu_en_i;
      end
      if (state_reg == LOAD && wait_cnt_reg == WAIT_W'(RD_LAT))
        bias_reg <= bias_rd_data_i;
    end
  end

  assign track_in = {add_en, add_en & pix_last, grp_cnt_reg};

  valid_delay_line #(
    .DEPTH (ADD_LAT),
    .WIDTH (GRP_W + 2)
  ) u_track (
    .clk (clk_i),
    .rst (rst_i),
    .d   (track_in),
    .q   (track_out)
  );

  assign busy_o         = (state_reg != IDLE);
  assign done_o         = (state_reg == DONE);
  assign bias_rd_en_o   = (state_reg == LOAD) && (wait_cnt_reg == '0);
  assign bias_rd_addr_o = cfg_base_reg + ADDR_W'(grp_cnt_reg);
  assign bias_o         = bias_reg;
  assign in_ready_o     = (state_reg == RUN);
  assign add_en_o       = add_en;
  assign skip_neg_en_o  = relu_reg;
  assign out_valid_o    = track_out[GRP_W+1];
  assign out_last_o     = track_out[GRP_W];
  assign grp_idx_o      = track_out[GRP_W-1:0];

endmodule

// File: tb/tb_bias_add_ctrl.sv
// Directed bench for bias_add_ctrl: cycle table for a full layer plus
// hand sequences for zero config, gaps, mid-run reset and start-while-busy.
module tb_bias_add_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [63:0] Z0 = 64'd0;
  localparam logic [63:0] BA = {8{8'hA5}};
  localparam logic [63:0] BC = {8{8'h3C}};

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  cfg_grp_num_i = '0;
  logic [15:0] cfg_pix_num_i = '0;
  logic [9:0]  cfg_bias_base_i = '0;
  logic        cfg_relu_en_i = 1'b0;
  logic        busy_o, done_o, bias_rd_en_o;
  logic [9:0]  bias_rd_addr_o;
  logic [63:0] bias_rd_data_i;
  logic [63:0] bias_o;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o, add_en_o, skip_neg_en_o;
  logic        out_valid_o, out_last_o;
  logic [7:0]  grp_idx_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bias_add_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .cfg_grp_num_i   (cfg_grp_num_i),
    .cfg_pix_num_i   (cfg_pix_num_i),
    .cfg_bias_base_i (cfg_bias_base_i),
    .cfg_relu_en_i   (cfg_relu_en_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .bias_rd_en_o    (bias_rd_en_o),
    .bias_rd_addr_o  (bias_rd_addr_o),
    .bias_rd_data_i  (bias_rd_data_i),
    .bias_o          (bias_o),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .add_en_o        (add_en_o),
    .skip_neg_en_o   (skip_neg_en_o),
    .out_valid_o     (out_valid_o),
    .out_last_o      (out_last_o),
    .grp_idx_o       (grp_idx_o)
  );

  // Bias buffer model with one cycle of read latency.
  function automatic logic [63:0] bias_word(input logic [9:0] a);
    if (a == 10'h010)      return BA;
    else if (a == 10'h011) return BC;
    else                   return {8{a[7:0]}};
  endfunction

  always @(posedge clk) begin
    if (rst_i)             bias_rd_data_i <= '0;
    else if (bias_rd_en_o) bias_rd_data_i <= bias_word(bias_rd_addr_o);
  end

  typedef struct {
    logic        start, vld, busy, ready, add, rd;
    logic [9:0]  addr;
    logic [63:0] bias;
    logic        ov, last;
    logic [7:0]  grp;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic v, input logic b, input logic r,
                              input logic a, input logic rd, input logic [9:0] ad,
                              input logic [63:0] bi, input logic o, input logic l,
                              input logic [7:0] g, input logic d);
    vec_t t;
    t.start = s; t.vld = v; t.busy = b; t.ready = r; t.add = a; t.rd = rd;
    t.addr = ad; t.bias = bi; t.ov = o; t.last = l; t.grp = g; t.done = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string t);
    chk($sformatf("%s busy", t),  64'(busy_o), Z0);
    chk($sformatf("%s done", t),  64'(done_o), Z0);
    chk($sformatf("%s rd_en", t), 64'(bias_rd_en_o), Z0);
    chk($sformatf("%s addr", t),  64'(bias_rd_addr_o), Z0);
    chk($sformatf("%s bias", t),  bias_o, Z0);
    chk($sformatf("%s ready", t), 64'(in_ready_o), Z0);
    chk($sformatf("%s add", t),   64'(add_en_o), Z0);
    chk($sformatf("%s skip", t),  64'(skip_neg_en_o), Z0);
    chk($sformatf("%s ov", t),    64'(out_valid_o), Z0);
    chk($sformatf("%s last", t),  64'(out_last_o), Z0);
    chk($sformatf("%s grp", t),   64'(grp_idx_o), Z0);
  endtask

  task automatic set_cfg(input logic [7:0] g, input logic [15:0] p,
                         input logic [9:0] b, input logic r);
    cfg_grp_num_i = g; cfg_pix_num_i = p; cfg_bias_base_i = b; cfg_relu_en_i = r;
  endtask

  initial begin
    // Basic layer: grp=2, pix=3, base=0x10, in_valid held high (cycle c0 = start).
    vecs.push_back(mk(H,H,L,L,L,L,10'h000,Z0,L,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,H,10'h010,Z0,L,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h010,Z0,L,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h010,BA,L,L,8'd0,L));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(L,H,H,H,H,L,10'h010,BA,L,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,H,10'h011,BA,H,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BA,H,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BC,H,H,8'd0,L));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(L,H,H,H,H,L,10'h011,BC,L,L,8'd0,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BC,H,L,8'd1,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BC,H,L,8'd1,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BC,H,H,8'd1,L));
    vecs.push_back(mk(L,H,H,L,L,L,10'h011,BC,L,L,8'd0,H));
    vecs.push_back(mk(L,H,L,L,L,L,10'h011,BC,L,L,8'd0,L));

    // Reset state, with in_valid high to show it is not admitted.
    in_valid_i = 1'b1;
    repeat (3) step();
    chk_rst("reset held");
    rst_i = 1'b0;
    #1;
    chk_rst("reset released");

    set_cfg(8'd2, 16'd3, 10'h010, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      start_i = vecs[i].start;
      in_valid_i = vecs[i].vld;
      #1;
      chk($sformatf("basic c%0d busy", i),  64'(busy_o), 64'(vecs[i].busy));
      chk($sformatf("basic c%0d ready", i), 64'(in_ready_o), 64'(vecs[i].ready));
      chk($sformatf("basic c%0d add", i),   64'(add_en_o), 64'(vecs[i].add));
      chk($sformatf("basic c%0d rd_en", i), 64'(bias_rd_en_o), 64'(vecs[i].rd));
      chk($sformatf("basic c%0d addr", i),  64'(bias_rd_addr_o), 64'(vecs[i].addr));
      chk($sformatf("basic c%0d bias", i),  bias_o, vecs[i].bias);
      chk($sformatf("basic c%0d ov", i),    64'(out_valid_o), 64'(vecs[i].ov));
      chk($sformatf("basic c%0d done", i),  64'(done_o), 64'(vecs[i].done));
      if (vecs[i].ov) begin
        chk($sformatf("basic c%0d last", i), 64'(out_last_o), 64'(vecs[i].last));
        chk($sformatf("basic c%0d grp", i),  64'(grp_idx_o), 64'(vecs[i].grp));
      end
      if (i == 1) chk("basic skip", 64'(skip_neg_en_o), 64'd1);
      step();
    end
    in_valid_i = 1'b0;

    // Zero config: grp=0, then pix=0.
    for (int z = 0; z < 2; z++) begin
      if (z == 0) set_cfg(8'd0, 16'd3, 10'h040, 1'b0);
      else        set_cfg(8'd2, 16'd0, 10'h040, 1'b0);
      start_i = 1'b1;
      #1;
      chk($sformatf("zero%0d rd_en c0", z), 64'(bias_rd_en_o), Z0);
      step();
      start_i = 1'b0;
      #1;
      chk($sformatf("zero%0d done c1", z), 64'(done_o), 64'd1);
      chk($sformatf("zero%0d rd_en c1", z), 64'(bias_rd_en_o), Z0);
      step();
      chk($sformatf("zero%0d done c2", z), 64'(done_o), Z0);
      chk($sformatf("zero%0d busy c2", z), 64'(busy_o), Z0);
      chk($sformatf("zero%0d rd_en c2", z), 64'(bias_rd_en_o), Z0);
    end

    // Backpressure gaps: in_valid 1,0,0,1,1 from the first ready cycle.
    begin
      logic [4:0] pat;
      logic       e_add, e_ov;
      pat = 5'b11001;  // pat[k] is the beat offered k cycles after first ready
      set_cfg(8'd1, 16'd3, 10'h020, 1'b0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 10; k++) begin
        in_valid_i = (k < 5) ? pat[k] : 1'b0;
        #1;
        e_add = (k < 5) ? pat[k] : 1'b0;
        e_ov  = (k >= 3 && k < 8) ? pat[k-3] : 1'b0;
        chk($sformatf("gap k%0d ready", k), 64'(in_ready_o), 64'(k < 5));
        chk($sformatf("gap k%0d add", k),   64'(add_en_o), 64'(e_add));
        chk($sformatf("gap k%0d ov", k),    64'(out_valid_o), 64'(e_ov));
        chk($sformatf("gap k%0d done", k),  64'(done_o), 64'(k == 8));
        if (e_ov) chk($sformatf("gap k%0d last", k), 64'(out_last_o), 64'(k == 7));
        if (k < 5) chk($sformatf("gap k%0d bias", k), bias_o, {8{8'h20}});
        if (k == 0) chk("gap skip", 64'(skip_neg_en_o), Z0);
        step();
      end
    end

    // Reset during group 1, beat 1.
    set_cfg(8'd2, 16'd3, 10'h010, 1'b1);
    start_i = 1'b1;
    in_valid_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    chk("midrst beat", 64'(add_en_o), 64'd1);
    chk("midrst grp1 bias", bias_o, BC);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    chk_rst("midrst after");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("midrst k%0d ov", k), 64'(out_valid_o), Z0);
      chk($sformatf("midrst k%0d done", k), 64'(done_o), Z0);
      step();
    end
    in_valid_i = 1'b0;

    // Start while busy: the second start and its config must be ignored.
    begin
      int n_ov, n_done, n_rd, n_last;
      n_ov = 0; n_done = 0; n_rd = 0; n_last = 0;
      set_cfg(8'd1, 16'd2, 10'h030, 1'b1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (4) step();
      set_cfg(8'd3, 16'd5, 10'h050, 1'b0);
      start_i = 1'b1;
      #1;
      chk("busy start in RUN", 64'(in_ready_o), 64'd1);
      step();
      start_i = 1'b0;
      in_valid_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (out_valid_o)  n_ov++;
        if (out_valid_o && out_last_o) n_last++;
        if (done_o)       n_done++;
        if (bias_rd_en_o) n_rd++;
        chk($sformatf("busy k%0d skip", k), 64'(skip_neg_en_o), 64'd1);
        step();
      end
      in_valid_i = 1'b0;
      chk("busy ov count",   64'(n_ov), 64'd2);
      chk("busy last count", 64'(n_last), 64'd1);
      chk("busy done count", 64'(n_done), 64'd1);
      chk("busy rd count",   64'(n_rd), Z0);
      chk("busy idle at end", 64'(busy_o), Z0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
